// File: rtl/fft_r2_seq_ctrl_if.sv
// Signal bundle between the radix-2 FFT sequencer and its environment:
// the run handshake, the data RAM / twiddle ROM ports and the butterfly handshake.
interface fft_r2_seq_ctrl_if #(
  parameter int LOG2N = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] ram_raddr;
  logic [LOG2N-2:0] tw_addr;
  logic             bf_go;
  logic             wren;
  logic             bf_done;
  logic [LOG2N-1:0] ram_waddr;
  logic             ram_we;

  // Sequencer side.
  modport master (
    input  start, wren, bf_done,
    output busy, done, ram_raddr, tw_addr, bf_go, ram_waddr, ram_we
  );

  // Environment side: host, RAM, twiddle ROM and serial butterfly.
  modport slave (
    output start, wren, bf_done,
    input  busy, done, ram_raddr, tw_addr, bf_go, ram_waddr, ram_we
  );
endinterface

// File: rtl/fft_r2_seq_ctrl.sv
// Sequencer / address generator for an in-place radix-2 DIT FFT held in one
// dual-port data RAM. Walks every stage and butterfly, issues read and twiddle
// addresses, hands each butterfly to a serial butterfly unit and steers its two
// result strobes back to the A and B locations.
module fft_r2_seq_ctrl #(
  parameter int LOG2N = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_r2_seq_ctrl_if.master bus
);
  localparam int AW   = LOG2N;          // data RAM address width
  localparam int JW   = LOG2N - 1;      // butterfly index / twiddle address width
  localparam int SW   = $clog2(LOG2N);  // stage counter width
  localparam int HALF = 1 << JW;        // butterflies per stage

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT, NEXT} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] stage, stage_nxt;
  logic [JW-1:0] j, j_nxt;
  logic          wr_sel, wr_sel_nxt;
  logic          load_addr;
  logic [AW-1:0] a_addr, b_addr;
  logic [JW-1:0] tw_q;
  logic [AW-1:0] a_c, b_c;
  logic [JW-1:0] tw_c, low_mask;

  // Butterfly addresses for the (stage, j) pair the FSM enters RD_A with:
  // A has a 0 inserted at bit `stage` of j, B sets that bit, and the twiddle
  // index is the in-group offset scaled up to the N-point twiddle table.
  always_comb begin
    low_mask = (JW'(1) << stage_nxt) - JW'(1);
    a_c      = {j_nxt & ~low_mask, 1'b0} | {1'b0, j_nxt & low_mask};
    b_c      = a_c | (AW'(1) << stage_nxt);
    tw_c     = (j_nxt & low_mask) << (JW - int'(stage_nxt));
  end

  // Next-state, counter and output decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_nxt     = state;
    stage_nxt     = stage;
    j_nxt         = j;
    wr_sel_nxt    = wr_sel;
    load_addr     = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.ram_raddr = '0;
    bus.tw_addr   = '0;
    bus.bf_go     = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_waddr = '0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RD_A;
          stage_nxt = '0;
          j_nxt     = '0;
          load_addr = 1'b1;
        end
      end
      RD_A: begin
        bus.busy      = 1'b1;
        bus.ram_raddr = a_addr;
        bus.tw_addr   = tw_q;
        state_nxt     = RD_B;
      end
      RD_B: begin
        bus.busy      = 1'b1;
        bus.ram_raddr = b_addr;
        bus.tw_addr   = tw_q;
        bus.bf_go     = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        bus.busy      = 1'b1;
        bus.ram_raddr = b_addr;
        bus.tw_addr   = tw_q;
        if (bus.wren) begin
          bus.ram_we    = 1'b1;
          bus.ram_waddr = wr_sel ? b_addr : a_addr;
          wr_sel_nxt    = ~wr_sel;
        end
        if (bus.bf_done) state_nxt = NEXT;
      end
      NEXT: begin
        wr_sel_nxt = 1'b0;
        bus.busy   = 1'b1;
        if (j != JW'(HALF - 1)) begin
          j_nxt     = j + JW'(1);
          state_nxt = RD_A;
          load_addr = 1'b1;
        end else if (stage != SW'(LOG2N - 1)) begin
          stage_nxt = stage + SW'(1);
          j_nxt     = '0;
          state_nxt = RD_A;
          load_addr = 1'b1;
        end else begin
          // Last butterfly retired: busy drops in the same cycle done pulses.
          bus.busy  = 1'b0;
          bus.done  = 1'b1;
          stage_nxt = '0;
          j_nxt     = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, counters and the per-butterfly address registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      stage  <= '0;
      j      <= '0;
      wr_sel <= 1'b0;
      a_addr <= '0;
      b_addr <= '0;
      tw_q   <= '0;
    end else begin
      state  <= state_nxt;
      stage  <= stage_nxt;
      j      <= j_nxt;
      wr_sel <= wr_sel_nxt;
      if (load_addr) begin
        a_addr <= a_c;
        b_addr <= b_c;
        tw_q   <= tw_c;
      end
    end
  end
endmodule
